// File: rtl/conv_window_scheduler_if.sv
// Handshake bundle between conv_window_scheduler and its neighbours.
//  master: scheduler side (drives window request, engine start, result write).
//  slave : window fetcher / conv engine / output buffer side.
// Signals:
//  win_req/win_row/win_col -> window request and its top-left coordinate
//  win_ack                 <- window loaded onto engine inputs
//  conv_start/conv_finish  level handshake with the 5x5 engine
//  conv_result             <- signed 16-bit engine result
//  res_valid/res_ready     result write handshake
//  res_data/res_addr       -> result and its row-major output address
interface conv_window_scheduler_if #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int K      = 5,
  parameter int STRIDE = 1
);
  localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - K) / STRIDE + 1;
  localparam int AW    = (OUT_W * OUT_H > 1) ? $clog2(OUT_W * OUT_H) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic          win_req;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          win_ack;
  logic          conv_start;
  logic          conv_finish;
  logic [15:0]   conv_result;
  logic          res_valid;
  logic          res_ready;
  logic [15:0]   res_data;
  logic [AW-1:0] res_addr;

  modport master (
    output win_req, win_row, win_col, conv_start, res_valid, res_data, res_addr,
    input  win_ack, conv_finish, conv_result, res_ready
  );

  modport slave (
    input  win_req, win_row, win_col, conv_start, res_valid, res_data, res_addr,
    output win_ack, conv_finish, conv_result, res_ready
  );
endinterface

// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler
//  Walks the output positions of one feature map row-major, requests each
//  KxK window, runs the engine start/finish level handshake, captures the
//  result (optionally ReLU-clamped) and writes it out with its address.
// Ports:
//  clk, rst_n  clock / synchronous active-low reset
//  start       1-cycle frame start pulse (ignored while busy)
//  abort       synchronous abort, returns to IDLE from any state
//  busy        high while a frame is in progress
//  done        1-cycle pulse after the last result is accepted
//  err         sticky engine timeout flag, cleared by an accepted start
//  bus         handshake bundle (master side), see conv_window_scheduler_if
module conv_window_scheduler #(
  parameter int IMG_W   = 32,
  parameter int IMG_H   = 32,
  parameter int K       = 5,
  parameter int STRIDE  = 1,
  parameter int RELU    = 0,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  output logic err,
  conv_window_scheduler_if.master bus
);
  localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - K) / STRIDE + 1;
  localparam int AW    = (OUT_W * OUT_H > 1) ? $clog2(OUT_W * OUT_H) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int TW    = $clog2(TIMEOUT + 1);

  // Window coordinates are tracked directly in pixel units; the last
  // position is recognised by its pixel coordinate rather than out_row/out_col.
  localparam logic [RW-1:0] ROW_LAST = RW'((OUT_H - 1) * STRIDE);
  localparam logic [CW-1:0] COL_LAST = CW'((OUT_W - 1) * STRIDE);
  localparam logic [RW-1:0] ROW_STEP = RW'(STRIDE);
  localparam logic [CW-1:0] COL_STEP = CW'(STRIDE);
  localparam logic [TW-1:0] WD_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ARM,
    DISARM,
    WRITE,
    DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] pos;
  logic [TW-1:0] wd;
  logic [15:0]   result_relu;

  always_comb begin
    result_relu = bus.conv_result;
    if (RELU != 0 && bus.conv_result[15]) result_relu = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      pos            <= '0;
      wd             <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      bus.win_req    <= 1'b0;
      bus.win_row    <= '0;
      bus.win_col    <= '0;
      bus.conv_start <= 1'b0;
      bus.res_valid  <= 1'b0;
      bus.res_data   <= '0;
      bus.res_addr   <= '0;
    end else if (abort) begin
      // err is intentionally left as-is
      state          <= IDLE;
      pos            <= '0;
      wd             <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      bus.win_req    <= 1'b0;
      bus.win_row    <= '0;
      bus.win_col    <= '0;
      bus.conv_start <= 1'b0;
      bus.res_valid  <= 1'b0;
      bus.res_data   <= '0;
      bus.res_addr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state       <= FETCH;
            busy        <= 1'b1;
            err         <= 1'b0;
            pos         <= '0;
            bus.win_row <= '0;
            bus.win_col <= '0;
            bus.win_req <= 1'b1;
          end
        end

        FETCH: begin
          if (bus.win_ack) begin
            state          <= ARM;
            bus.win_req    <= 1'b0;
            bus.conv_start <= 1'b1;
            wd             <= '0;
          end
        end

        ARM: begin
          // A finish level already high on entry counts as completion.
          if (bus.conv_finish) begin
            state          <= DISARM;
            bus.conv_start <= 1'b0;
            bus.res_data   <= result_relu;
            wd             <= '0;
          end else if (wd == WD_LAST) begin
            state          <= IDLE;
            bus.conv_start <= 1'b0;
            busy           <= 1'b0;
            err            <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end

        DISARM: begin
          if (!bus.conv_finish) begin
            state         <= WRITE;
            bus.res_valid <= 1'b1;
            bus.res_addr  <= pos;
          end else if (wd == WD_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end

        WRITE: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            if (bus.win_row == ROW_LAST && bus.win_col == COL_LAST) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state       <= FETCH;
              bus.win_req <= 1'b1;
              pos         <= pos + 1'b1;
              if (bus.win_col == COL_LAST) begin
                bus.win_col <= '0;
                bus.win_row <= bus.win_row + ROW_STEP;
              end else begin
                bus.win_col <= bus.win_col + COL_STEP;
              end
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule
